// File: rtl/if_id_skid_reg_if.sv
// Fetch/decode handshake bundle for if_id_skid_reg. The perf counter wires
// exist only when IF_ID_PERF_EN is defined.
interface if_id_skid_reg_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic            InstrValidF;
   logic            InstrReadyF;
   logic [31:0]     InstrF;
   logic [XLEN-1:0] PCF;
   logic [XLEN-1:0] PCPlus4F;
   logic            StallD;
   logic            FlushD;
   logic            ValidD;
   logic [31:0]     InstrD;
   logic [XLEN-1:0] PCD;
   logic [XLEN-1:0] PCPlus4D;
`ifdef IF_ID_PERF_EN
   logic [CNT_W-1:0] StallCntD;
   logic [CNT_W-1:0] FlushCntD;
`endif

   // Environment side: fetch unit, hazard unit and decode stage.
   modport master (
      output InstrValidF, InstrF, PCF, PCPlus4F, StallD, FlushD,
      input  InstrReadyF, ValidD, InstrD, PCD, PCPlus4D
`ifdef IF_ID_PERF_EN
      , input StallCntD, FlushCntD
`endif
   );

   // Pipeline register side.
   modport slave (
      input  InstrValidF, InstrF, PCF, PCPlus4F, StallD, FlushD,
      output InstrReadyF, ValidD, InstrD, PCD, PCPlus4D
`ifdef IF_ID_PERF_EN
      , output StallCntD, FlushCntD
`endif
   );
endinterface

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer; flushes and empty slots
// become NOP bubbles. Optional perf counters are enabled with IF_ID_PERF_EN.
module if_id_skid_reg #(
   parameter int          XLEN      = 32,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter int          CNT_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   if_id_skid_reg_if.slave    bus,
   output logic [1:0]         dbg_state_o
);

   // Handshake: a fetch word transfers on a rising edge where InstrValidF and
   // InstrReadyF are both high; the decode slot retires where ValidD=1 and StallD=0.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     d_instr_q, d_instr_d;
   logic [XLEN-1:0] d_pc_q, d_pc_d;
   logic [XLEN-1:0] d_pc4_q, d_pc4_d;
   logic [31:0]     s_instr_q, s_instr_d;
   logic [XLEN-1:0] s_pc_q, s_pc_d;
   logic [XLEN-1:0] s_pc4_q, s_pc4_d;

   logic ready;
   logic d_valid;
   logic s_valid;
   logic push;
   logic adv;

   assign ready   = (state_q != ST_TWO);
   assign d_valid = (state_q != ST_EMPTY);
   assign s_valid = (state_q == ST_TWO);
   assign push    = bus.InstrValidF & ready;
   assign adv     = d_valid & ~bus.StallD;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_EMPTY;
         d_instr_q <= NOP_INSTR;
         d_pc_q    <= '0;
         d_pc4_q   <= '0;
         s_instr_q <= NOP_INSTR;
         s_pc_q    <= '0;
         s_pc4_q   <= '0;
      end else begin
         state_q   <= state_d;
         d_instr_q <= d_instr_d;
         d_pc_q    <= d_pc_d;
         d_pc4_q   <= d_pc4_d;
         s_instr_q <= s_instr_d;
         s_pc_q    <= s_pc_d;
         s_pc4_q   <= s_pc4_d;
      end
   end

   // PC fields are left alone when the slot empties so PCD keeps its last value.
   always_comb begin
      state_d   = state_q;
      d_instr_d = d_instr_q;
      d_pc_d    = d_pc_q;
      d_pc4_d   = d_pc4_q;
      s_instr_d = s_instr_q;
      s_pc_d    = s_pc_q;
      s_pc4_d   = s_pc4_q;

      if (bus.FlushD) begin
         state_d   = ST_EMPTY;
         d_instr_d = NOP_INSTR;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  state_d   = ST_ONE;
                  d_instr_d = bus.InstrF;
                  d_pc_d    = bus.PCF;
                  d_pc4_d   = bus.PCPlus4F;
               end
            end
            ST_ONE: begin
               if (push && adv) begin
                  d_instr_d = bus.InstrF;
                  d_pc_d    = bus.PCF;
                  d_pc4_d   = bus.PCPlus4F;
               end else if (push) begin
                  state_d   = ST_TWO;
                  s_instr_d = bus.InstrF;
                  s_pc_d    = bus.PCF;
                  s_pc4_d   = bus.PCPlus4F;
               end else if (adv) begin
                  state_d   = ST_EMPTY;
                  d_instr_d = NOP_INSTR;
               end
            end
            ST_TWO: begin
               if (adv) begin
                  state_d   = ST_ONE;
                  d_instr_d = s_instr_q;
                  d_pc_d    = s_pc_q;
                  d_pc4_d   = s_pc4_q;
               end
            end
            default: begin
               state_d   = ST_EMPTY;
               d_instr_d = NOP_INSTR;
            end
         endcase
      end
   end

   assign bus.InstrReadyF = ready;
   assign bus.ValidD      = d_valid;
   assign bus.InstrD      = d_instr_q;
   assign bus.PCD         = d_pc_q;
   assign bus.PCPlus4D    = d_pc4_q;
   assign dbg_state_o     = state_q;

`ifdef IF_ID_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // Both counters stick at all-ones rather than wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (d_valid && bus.StallD && !(&stall_cnt_q))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (bus.FlushD && (d_valid || s_valid) && !(&flush_cnt_q))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.StallCntD = stall_cnt_q;
   assign bus.FlushCntD = flush_cnt_q;
`endif

endmodule
